// File: rtl/vga_scene_pkg.sv
// Shared constants for the VGA scene controller: entity codes, FSM encoding and helpers.
package vga_scene_pkg;

    localparam int ENT_W = 2;

    typedef logic [ENT_W-1:0] ent_t;

    localparam ent_t ENT_0 = 2'b00;
    localparam ent_t ENT_1 = 2'b01;
    localparam ent_t ENT_2 = 2'b10;
    localparam ent_t ENT_3 = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ATTR = 2'd2;

    // Attract mode steps through the entity codes in order, wrapping 3 -> 0.
    function automatic ent_t next_ent(input ent_t e);
        return e + ent_t'(1);
    endfunction

endpackage

// File: rtl/vga_scene_ctrl_frame_tick_gen.sv
// Frame boundary detector: one-cycle tick on the falling edge of the active-low vsync.
module frame_tick_gen (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic vsync_i,
    output logic tick_o
);

    logic vs_q;

    // Resetting to 1 means a vsync that is already low at release counts as a boundary.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vsync_i;
        end
    end

    assign tick_o = vs_q & ~vsync_i;

endmodule

// File: rtl/vga_scene_ctrl.sv
// Frame-synchronous scene controller for vga_draw: applies entity changes only on vsync.
// Optional attract mode (idle entity cycling) is built when VGA_SCENE_ATTRACT_EN is defined.
module vga_scene_ctrl
    import vga_scene_pkg::*;
#(
    parameter int unsigned      MIN_HOLD_FRAMES = 4,
    parameter int unsigned      IDLE_FRAMES     = 600,
    parameter logic [ENT_W-1:0] RESET_ENT       = ENT_3
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic             vga_vsync,
    input  logic             req_valid,
    input  logic [ENT_W-1:0] req_ent,
    output logic             req_ready,
    input  logic             color_tgl,
    output logic [ENT_W-1:0] ent_code,
    output logic             color_sel,
    output logic             update_pulse,
    output logic             attract_active
);

    localparam logic [7:0] HOLD_MAX = 8'(MIN_HOLD_FRAMES);

    logic             tick;
    logic             accept;
    logic             hold_ok;
    logic             apply;
    logic             idle_expired;

    logic [1:0]       state_q, state_d;
    logic [ENT_W-1:0] ent_q, ent_d;
    logic [ENT_W-1:0] pend_ent_q, pend_ent_d;
    logic [7:0]       hold_q, hold_d;
    logic             color_q, color_d;
    logic             tgl_q, tgl_d;
    logic             pulse_q;

    frame_tick_gen u_tick (
        .clk_i   (sys_clk),
        .rst_n_i (sys_reset_n),
        .vsync_i (vga_vsync),
        .tick_o  (tick)
    );

    assign req_ready = sys_reset_n & (state_q != S_PEND);
    assign accept    = req_valid & req_ready;
    assign hold_ok   = (hold_q == HOLD_MAX);

`ifdef VGA_SCENE_ATTRACT_EN
    localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_FRAMES);

    logic [15:0] idle_q, idle_d;
    logic        attr_q;

    assign idle_expired = (state_q == S_IDLE) & ~accept & tick & (idle_q + 16'd1 == IDLE_LIMIT);

    // Counter only advances on idle ticks; anything else (acceptance, other states) restarts it.
    always_comb begin
        idle_d = idle_q;
        if (accept || state_q != S_IDLE || idle_expired) begin
            idle_d = '0;
        end else if (tick) begin
            idle_d = idle_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            idle_q <= '0;
            attr_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
            attr_q <= (state_d == S_ATTR);
        end
    end

    assign attract_active = attr_q;
`else
    assign idle_expired   = 1'b0;
    assign attract_active = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ent_d      = ent_q;
        pend_ent_d = pend_ent_q;
        apply      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_ent != ent_q) begin
                        pend_ent_d = req_ent;
                        state_d    = S_PEND;
                    end
                end else if (idle_expired) begin
                    state_d = S_ATTR;
                end
            end
            S_PEND: begin
                if (tick && hold_ok) begin
                    ent_d   = pend_ent_q;
                    apply   = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef VGA_SCENE_ATTRACT_EN
            // A request wins over an attract step landing in the same cycle.
            S_ATTR: begin
                if (accept) begin
                    if (req_ent != ent_q) begin
                        pend_ent_d = req_ent;
                        state_d    = S_PEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tick && hold_ok) begin
                    ent_d = next_ent(ent_q);
                    apply = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        if (apply) begin
            hold_d = '0;
        end else if (tick && !hold_ok) begin
            hold_d = hold_q + 8'd1;
        end
    end

    // A toggle arriving on a tick re-arms the flag, so it flips one frame later.
    assign tgl_d   = color_tgl | (tgl_q & ~tick);
    assign color_d = color_q ^ (tick & tgl_q);

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            state_q    <= S_IDLE;
            ent_q      <= RESET_ENT;
            pend_ent_q <= RESET_ENT;
            hold_q     <= HOLD_MAX;
            color_q    <= 1'b0;
            tgl_q      <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ent_q      <= ent_d;
            pend_ent_q <= pend_ent_d;
            hold_q     <= hold_d;
            color_q    <= color_d;
            tgl_q      <= tgl_d;
            pulse_q    <= apply;
        end
    end

    assign ent_code     = ent_q;
    assign color_sel    = color_q;
    assign update_pulse = pulse_q;

endmodule

// File: tb/tb_vga_scene_ctrl.sv
// Directed plus randomized bench for vga_scene_ctrl against a frame-level reference model.
// Attract-mode steps are exercised when VGA_SCENE_ATTRACT_EN is defined.
module tb_vga_scene_ctrl;

    localparam int MIN_HOLD  = 4;
    localparam int IDLE_FR   = 8;
    localparam int FRAME_LEN = 24;

    logic       sys_clk = 1'b0;
    logic       sys_reset_n;
    logic       vga_vsync;
    logic       req_valid;
    logic [1:0] req_ent;
    logic       color_tgl;
    logic       req_ready;
    logic [1:0] ent_code;
    logic       color_sel;
    logic       update_pulse;
    logic       attract_active;

    int checks  = 0;
    int errors  = 0;
    int phase   = 0;
    int cycleNo = 0;

    // Reference model: tracks frames by tick number rather than counters or states.
    logic       curRst;
    logic [1:0] mEnt;
    logic       mColor;
    logic       mPulse;
    logic       mAttr;
    logic       mTglWaiting;
    logic       mPrevVs;
    logic       mTick;
    logic [1:0] mPendQ[$];
    int         mTickNo;
    int         mLastApply;
    int         mIdleSince;

    always #5 sys_clk = ~sys_clk;

    vga_scene_ctrl #(
        .MIN_HOLD_FRAMES (MIN_HOLD),
        .IDLE_FRAMES     (IDLE_FR),
        .RESET_ENT       (2'b11)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_reset_n    (sys_reset_n),
        .vga_vsync      (vga_vsync),
        .req_valid      (req_valid),
        .req_ent        (req_ent),
        .req_ready      (req_ready),
        .color_tgl      (color_tgl),
        .ent_code       (ent_code),
        .color_sel      (color_sel),
        .update_pulse   (update_pulse),
        .attract_active (attract_active)
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycleNo);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycleNo, obs, exp);
        end
    endtask

    task automatic modelReset();
        mEnt        = 2'b11;
        mColor      = 1'b0;
        mPulse      = 1'b0;
        mAttr       = 1'b0;
        mTglWaiting = 1'b0;
        mPrevVs     = 1'b1;
        mTick       = 1'b0;
        mPendQ.delete();
        mTickNo     = 0;
        mLastApply  = -1000;
        mIdleSince  = 0;
    endtask

    task automatic modelStep(input logic rst, input logic vs, input logic valid,
                             input logic [1:0] ent, input logic tgl);
        logic holdOk;
        logic accept;
        logic flip;
        if (!rst) begin
            modelReset();
        end else begin
            mPulse  = 1'b0;
            mTick   = mPrevVs && !vs;
            mPrevVs = vs;
            if (mTick) mTickNo++;
            holdOk = (mTickNo - mLastApply) > MIN_HOLD;
            accept = valid && (mPendQ.size() == 0);
            if (accept) begin
                mAttr      = 1'b0;
                mIdleSince = mTickNo;
                if (ent != mEnt) mPendQ.push_back(ent);
            end else if (mPendQ.size() != 0 && mTick && holdOk) begin
                mEnt       = mPendQ.pop_front();
                mPulse     = 1'b1;
                mLastApply = mTickNo;
                mIdleSince = mTickNo;
            end else if (mAttr && mTick && holdOk) begin
                mEnt       = 2'((int'(mEnt) + 1) % 4);
                mPulse     = 1'b1;
                mLastApply = mTickNo;
            end
`ifdef VGA_SCENE_ATTRACT_EN
            else if (!mAttr && mPendQ.size() == 0 && mTick && (mTickNo - mIdleSince == IDLE_FR)) begin
                mAttr = 1'b1;
            end
`endif
            flip = mTick && mTglWaiting;
            if (flip) mColor = !mColor;
            if (tgl) mTglWaiting = 1'b1;
            else if (flip) mTglWaiting = 1'b0;
        end
    endtask

    task automatic checkOutput();
        checkVal("req_ready", {1'b0, req_ready}, {1'b0, curRst && mPendQ.size() == 0});
        checkVal("ent_code", ent_code, mEnt);
        checkVal("color_sel", {1'b0, color_sel}, {1'b0, mColor});
        checkVal("update_pulse", {1'b0, update_pulse}, {1'b0, mPulse});
        checkVal("attract_active", {1'b0, attract_active}, {1'b0, mAttr});
    endtask

    task automatic applyStimulus(input logic rst, input logic valid, input logic [1:0] ent, input logic tgl);
        logic vs;
        @(negedge sys_clk);
        checkOutput();
        vs = !(phase >= 20 && phase <= 22);
        sys_reset_n = rst;
        vga_vsync   = vs;
        req_valid   = valid;
        req_ent     = ent;
        color_tgl   = tgl;
        modelStep(rst, vs, valid, ent, tgl);
        curRst = rst;
        phase  = (phase + 1) % FRAME_LEN;
        cycleNo++;
        @(posedge sys_clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic idleToPhase(input int p);
        for (int i = 0; i < FRAME_LEN && phase != p; i++) idleCycles(1);
    endtask

    task automatic idleUntilPulse(input string tag, input int bound);
        for (int i = 0; i < bound && !mPulse; i++) idleCycles(1);
        checkVal(tag, {1'b0, mPulse}, 2'b01);
    endtask

    initial begin
        logic [1:0] want;
        sys_reset_n = 1'b0;
        vga_vsync   = 1'b1;
        req_valid   = 1'b0;
        req_ent     = 2'b00;
        color_tgl   = 1'b0;
        curRst      = 1'b0;
        modelReset();
        repeat (2) @(posedge sys_clk);

        // Reset release
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
        #1;
        checkVal("rst_ent", ent_code, 2'b11);
        checkVal("rst_color", {1'b0, color_sel}, 2'b00);
        checkVal("rst_ready", {1'b0, req_ready}, 2'b01);

        // First request mid-frame applies at the next tick
        idleToPhase(5);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0);
        #1;
        checkVal("pend_ready", {1'b0, req_ready}, 2'b00);
        idleUntilPulse("first_apply_timeout", 60);
        #1;
        checkVal("first_apply_ent", ent_code, 2'd1);
        checkVal("first_apply_pulse", {1'b0, update_pulse}, 2'b01);

        // Back-to-back request held off by the minimum display time
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0);
        idleUntilPulse("second_apply_timeout", 300);
        #1;
        checkVal("second_apply_ent", ent_code, 2'd2);

        // Same-code request is swallowed
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0);
        #1;
        checkVal("same_code_pulse", {1'b0, update_pulse}, 2'b00);
        checkVal("same_code_ready", {1'b0, req_ready}, 2'b01);

        // Two toggles in a frame give one flip; a toggle on the tick waits a frame
        idleToPhase(3);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
        idleCycles(4);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
        idleToPhase(21);
        #1;
        checkVal("double_toggle_color", {1'b0, color_sel}, 2'b01);
        idleToPhase(20);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
        #1;
        checkVal("tick_toggle_hold", {1'b0, color_sel}, 2'b01);
        idleCycles(FRAME_LEN);
        #1;
        checkVal("tick_toggle_flip", {1'b0, color_sel}, 2'b00);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 19) == 0);
        end

        // Reset while a request is pending drops it
        idleCycles(FRAME_LEN);
        idleToPhase(2);
        want = 2'((int'(mEnt) + 1) % 4);
        applyStimulus(1'b1, 1'b1, want, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
        #1;
        checkVal("midreset_ent", ent_code, 2'b11);
        checkVal("midreset_ready", {1'b0, req_ready}, 2'b01);
        idleCycles(2 * FRAME_LEN);
        #1;
        checkVal("midreset_no_apply", ent_code, 2'b11);

`ifdef VGA_SCENE_ATTRACT_EN
        // Attract entry, cycling, and exit on request
        for (int i = 0; i < 20 * FRAME_LEN && !mAttr; i++) idleCycles(1);
        #1;
        checkVal("attract_entry", {1'b0, attract_active}, 2'b01);
        idleCycles(15 * FRAME_LEN);
        idleToPhase(6);
        want = 2'((int'(mEnt) + 2) % 4);
        applyStimulus(1'b1, 1'b1, want, 1'b0);
        #1;
        checkVal("attract_exit", {1'b0, attract_active}, 2'b00);
        checkVal("attract_exit_ready", {1'b0, req_ready}, 2'b00);
        idleUntilPulse("attract_apply_timeout", 300);
        #1;
        checkVal("attract_apply_ent", ent_code, want);
        idleCycles(3 * FRAME_LEN);
`else
        idleCycles(12 * FRAME_LEN);
        #1;
        checkVal("no_attract", {1'b0, attract_active}, 2'b00);
`endif

        @(negedge sys_clk);
        checkOutput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scene_ctrl.md
# vga_scene_ctrl

Frame-synchronous scene controller for the VGA draw path: it owns the `ent` entity code and the colour-select input of `vga_draw`. Game and joystick logic issue entity-change requests through a valid/ready handshake. The block applies them only at a vertical-sync boundary and enforces a minimum display time per entity, so the picture never changes mid-frame and never flickers between codes.

## Interface
- `MIN_HOLD_FRAMES`, default 4: frame boundaries that must pass after an apply before the next apply; range 1..255.
- `IDLE_FRAMES`, default 600: frame boundaries with no accepted request before attract mode starts; used only with the macro; range 1..65535.
- `RESET_ENT`, default 2'b11: entity code after reset.
- `sys_clk` in, 1: clock. The integrator drives it from the pixel clock, the same clock that feeds `vga_draw`.
- `sys_reset_n` in, 1: reset, synchronous, active-low.
- `vga_vsync` in, 1: vsync from `vga_draw`, active-low, in the `sys_clk` domain.
- `req_valid` in, 1: entity-change request valid.
- `req_ent` in, 2: requested entity code.
- `req_ready` out, 1: request accepted when `req_valid & req_ready`.
- `color_tgl` in, 1: one-cycle pulse requesting a colour swap.
- `ent_code` out, 2: registered; drives `vga_draw.ent`.
- `color_sel` out, 1: registered; drives `vga_draw.iColor_SW`.
- `update_pulse` out, 1: registered; high for one cycle when `ent_code` changes.
- `attract_active` out, 1: registered; high while in attract state, tied 0 without the macro.

## Operation
- Frame tick:
  - `vs_q` is `vga_vsync` delayed one cycle; it resets to 1.
  - `tick = vs_q & ~vga_vsync`, i.e. the vsync falling edge.
- Hold counter `hold_cnt`, 8 bits:
  - reset value is `MIN_HOLD_FRAMES`;
  - +1 per tick, saturating at `MIN_HOLD_FRAMES`;
  - cleared to 0 on every apply;
  - `hold_ok = (hold_cnt == MIN_HOLD_FRAMES)`, using the value before that tick's increment.
- FSM states: S_IDLE, S_PEND, S_ATTR. Reset state is S_IDLE.
- S_IDLE:
  - `req_ready` = 1.
  - Accept with `req_ent != ent_code`: latch into `pend_ent`, go to S_PEND.
  - Accept with `req_ent == ent_code`: discard, stay in S_IDLE, no pulse.
- S_PEND:
  - `req_ready` = 0.
  - On `tick & hold_ok`: `ent_code <= pend_ent`, `update_pulse <= 1`, clear `hold_cnt`, go to S_IDLE.
  - A tick without `hold_ok` keeps waiting.
- A `tick` in the same cycle as acceptance is not used for that request; the earliest apply is the next tick.
- Colour toggle:
  - `color_tgl` sets the `tgl_pend` flag;
  - on the next `tick`, `color_sel` flips and `tgl_pend` clears;
  - a toggle coinciding with a tick flips at the following tick;
  - further toggles while `tgl_pend` is set are absorbed, giving one flip.
- `color_sel` and `ent_code` may change on the same tick.
- Reset asserted mid-operation:
  - the pending request and pending toggle are dropped;
  - all registers return to reset values on that edge;
  - `req_ready` = 0 while `sys_reset_n` is low.
- Output reset values:
  - `ent_code` = `RESET_ENT`;
  - `color_sel` = 0, `update_pulse` = 0, `attract_active` = 0;
  - `req_ready` = 0 during reset, 1 in the first cycle after release.

## Timing
- `req_ready` is combinational from the state, with no dependency on `req_valid`.
- Vsync falls, i.e. `vga_vsync` = 0 is sampled, in cycle t: `tick` is high in cycle t, and `ent_code`, `color_sel` and `update_pulse` update at the end of cycle t. The latency from the vsync falling edge is therefore one clock.
- Minimum spacing between applies is `MIN_HOLD_FRAMES`+1 ticks.
- The first request after reset applies at the first tick after acceptance.

## Configuration
- `VGA_SCENE_ATTRACT_EN` defined:
  - Idle counter, 16 bits: counts ticks in S_IDLE and clears on any acceptance.
  - Entry: at `IDLE_FRAMES`, go to S_ATTR and set `attract_active` = 1.
  - In S_ATTR, on each `tick & hold_ok`: `ent_code <= ent_code + 1` (wrapping 3→0), `update_pulse` fires, `hold_cnt` clears.
  - Requests: `req_ready` = 1 in S_ATTR. An acceptance clears `attract_active` and handles the request exactly as in S_IDLE, going to S_PEND or, for a same-code request, to S_IDLE.
- Macro undefined: no idle counter and no S_ATTR; `attract_active` is tied to 0.

## Structure
- Shared package `vga_scene_pkg`:
  - entity code constants: ENT_0..ENT_3, with ENT_3 = 2'b11;
  - FSM state encoding;
  - `ENT_W` = 2.
- One sub-module, `frame_tick_gen`: owns the vsync delay register and the `tick` output.

## Test plan
- Reset release with MIN_HOLD_FRAMES=4 -> `ent_code`=3, `color_sel`=0, `req_ready`=1 next cycle.
- Request with `req_ent`=1 accepted mid-frame -> `req_ready`=0, `ent_code` becomes 1 one cycle after the next vsync falling edge, single `update_pulse`.
- Second request `req_ent`=2 right after the apply -> ignored through 4 ticks, applied on the 5th tick.
- Request `req_ent` equal to the current `ent_code` -> accepted, no `update_pulse`, state stays S_IDLE.
- Two `color_tgl` pulses within one frame -> exactly one `color_sel` flip at the next tick; a toggle on the tick cycle flips one frame later.
- With the macro and IDLE_FRAMES=8 -> after 8 ticks `attract_active`=1 and `ent_code` cycles 3→0→1 every 5 ticks. A request then clears `attract_active` and the request is applied at the next allowed tick. Reset asserted while in S_PEND clears the pending request.
